// File: rtl/exe_mem.sv
// EXE/MEM pipeline register: captures the execute result and memory request, traps
// misaligned halfword/word accesses, and flags load-use hazards against decode.
module exe_mem #(
  parameter int CHECK_ALIGN = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic                   id_rs1_re_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                   id_rs2_re_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_data_o,
  output logic [3:0]             mem_op_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   misalign_o,
  output logic [ADDR_WIDTH-1:0]  misalign_addr_o,
  output logic [ADDR_WIDTH-1:0]  misalign_pc_o,
  output logic                   load_use_o,
  output logic [CNT_WIDTH-1:0]   bubble_cnt_o
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic                   reg_we_q, reg_we_d;
  logic [RDATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_data_q, mem_data_d;
  logic [3:0]             mem_op_q, mem_op_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0]  mis_addr_q, mis_addr_d;
  logic [ADDR_WIDTH-1:0]  mis_pc_q, mis_pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic is_half, is_word, trap, capture, load_bubble, is_load, rs_hit;

  always_comb begin
    is_half = (mem_op_i == MEM_LH) || (mem_op_i == MEM_LHU) || (mem_op_i == MEM_SH);
    is_word = (mem_op_i == MEM_LW) || (mem_op_i == MEM_SW);
    trap    = (CHECK_ALIGN != 0) &&
              ((is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00)));
    // Flush overrides stall; a trap only matters on an edge that would capture.
    capture     = !flush_i && !stall_i;
    load_bubble = flush_i || (capture && trap);
  end

  always_comb begin
    reg_waddr_d = reg_waddr_q;
    reg_we_d    = reg_we_q;
    reg_wdata_d = reg_wdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_op_d    = mem_op_q;
    pc_d        = pc_q;
    misalign_d  = capture && trap;
    mis_addr_d  = mis_addr_q;
    mis_pc_d    = mis_pc_q;
    cnt_d       = cnt_q;
    if (load_bubble) begin
      reg_waddr_d = '0;
      reg_we_d    = 1'b0;
      reg_wdata_d = '0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_data_d  = '0;
      mem_op_d    = MEM_NOP;
      pc_d        = '0;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (capture) begin
      reg_waddr_d = reg_waddr_i;
      reg_we_d    = reg_we_i;
      reg_wdata_d = reg_wdata_i;
      mem_we_d    = mem_we_i;
      mem_addr_d  = mem_addr_i;
      mem_data_d  = mem_data_i;
      mem_op_d    = mem_op_i;
      pc_d        = pc_i;
    end
    if (capture && trap) begin
      mis_addr_d = mem_addr_i;
      mis_pc_d   = pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_waddr_q <= '0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_op_q    <= MEM_NOP;
      pc_q        <= '0;
      misalign_q  <= 1'b0;
      mis_addr_q  <= '0;
      mis_pc_q    <= '0;
      cnt_q       <= '0;
    end else begin
      reg_waddr_q <= reg_waddr_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_op_q    <= mem_op_d;
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      mis_addr_q  <= mis_addr_d;
      mis_pc_q    <= mis_pc_d;
      cnt_q       <= cnt_d;
    end
  end

  // Hazard only against real loads writing a non-zero register.
  always_comb begin
    is_load = (mem_op_i == MEM_LB) || (mem_op_i == MEM_LBU) || (mem_op_i == MEM_LH) ||
              (mem_op_i == MEM_LHU) || (mem_op_i == MEM_LW);
    rs_hit  = (id_rs1_re_i && (id_rs1_addr_i == reg_waddr_i)) ||
              (id_rs2_re_i && (id_rs2_addr_i == reg_waddr_i));
    load_use_o = !rst_i && is_load && reg_we_i && (reg_waddr_i != '0) && rs_hit;
  end

  assign reg_waddr_o     = reg_waddr_q;
  assign reg_we_o        = reg_we_q;
  assign reg_wdata_o     = reg_wdata_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_o      = mem_data_q;
  assign mem_op_o        = mem_op_q;
  assign pc_o            = pc_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = mis_addr_q;
  assign misalign_pc_o   = mis_pc_q;
  assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_exe_mem.sv
// Directed, table-driven bench for exe_mem; a second instance with a 4-bit counter
// covers bubble-counter saturation.
module tb_exe_mem;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] pc, wdata, addr, mdata;
  logic [4:0]  waddr, rs1, rs2;
  logic        we, mem_we, rs1re, rs2re;
  logic [3:0]  op;

  logic [4:0]  waddr_o, waddr4_o;
  logic        we_o, mem_we_o, mis_o, lu_o, we4_o, mem_we4_o, mis4_o, lu4_o;
  logic [31:0] wdata_o, addr_o, mdata_o, pc_o, mis_addr_o, mis_pc_o;
  logic [31:0] wdata4_o, addr4_o, mdata4_o, pc4_o, mis_addr4_o, mis_pc4_o;
  logic [3:0]  op_o, op4_o;
  logic [15:0] cnt_o;
  logic [3:0]  cnt4_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  exe_mem dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .pc_i(pc),
    .reg_waddr_i(waddr), .reg_we_i(we), .reg_wdata_i(wdata), .mem_we_i(mem_we),
    .mem_addr_i(addr), .mem_data_i(mdata), .mem_op_i(op),
    .id_rs1_addr_i(rs1), .id_rs1_re_i(rs1re), .id_rs2_addr_i(rs2), .id_rs2_re_i(rs2re),
    .reg_waddr_o(waddr_o), .reg_we_o(we_o), .reg_wdata_o(wdata_o), .mem_we_o(mem_we_o),
    .mem_addr_o(addr_o), .mem_data_o(mdata_o), .mem_op_o(op_o), .pc_o(pc_o),
    .misalign_o(mis_o), .misalign_addr_o(mis_addr_o), .misalign_pc_o(mis_pc_o),
    .load_use_o(lu_o), .bubble_cnt_o(cnt_o)
  );

  exe_mem #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .pc_i(pc),
    .reg_waddr_i(waddr), .reg_we_i(we), .reg_wdata_i(wdata), .mem_we_i(mem_we),
    .mem_addr_i(addr), .mem_data_i(mdata), .mem_op_i(op),
    .id_rs1_addr_i(rs1), .id_rs1_re_i(rs1re), .id_rs2_addr_i(rs2), .id_rs2_re_i(rs2re),
    .reg_waddr_o(waddr4_o), .reg_we_o(we4_o), .reg_wdata_o(wdata4_o), .mem_we_o(mem_we4_o),
    .mem_addr_o(addr4_o), .mem_data_o(mdata4_o), .mem_op_o(op4_o), .pc_o(pc4_o),
    .misalign_o(mis4_o), .misalign_addr_o(mis_addr4_o), .misalign_pc_o(mis_pc4_o),
    .load_use_o(lu4_o), .bubble_cnt_o(cnt4_o)
  );

  typedef struct {
    logic        stall, flush;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        mem_we;
    logic [31:0] addr, mdata;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic        rs1re;
    logic [4:0]  rs2;
    logic        rs2re;
    logic [3:0]  e_op;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_mem_we;
    logic [31:0] e_addr, e_mdata, e_pc;
    logic        e_mis, e_lu;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive_idle();
    stall = 0; flush = 0; pc = 0; waddr = 0; we = 0; wdata = 0; mem_we = 0;
    addr = 0; mdata = 0; op = 0; rs1 = 0; rs1re = 0; rs2 = 0; rs2re = 0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_op"}, -1, {28'd0, op_o}, 32'd0);
    check({tag, "_we"}, -1, {31'd0, we_o}, 32'd0);
    check({tag, "_waddr"}, -1, {27'd0, waddr_o}, 32'd0);
    check({tag, "_addr"}, -1, addr_o, 32'd0);
    check({tag, "_pc"}, -1, pc_o, 32'd0);
  endtask

  initial begin
    // Bubble columns: op=0 we=0 waddr=0 wdata=0 mem_we=0 addr=0 mdata=0 pc=0
    vecs[0]  = '{0,0,'h10,0,0,0,1,'h100,'hDEADBEEF,8,0,0,0,0, 8,0,0,0,1,'h100,'hDEADBEEF,'h10,0,0,0};
    vecs[1]  = '{0,0,'h14,5,1,'h12,0,0,0,0,0,0,0,0, 0,1,5,'h12,0,0,0,'h14,0,0,0};
    vecs[2]  = '{1,0,'h18,9,1,'h99,0,0,0,0,0,0,0,0, 0,1,5,'h12,0,0,0,'h14,0,0,0};
    vecs[3]  = '{1,0,'h18,9,1,'h99,0,0,0,0,0,0,0,0, 0,1,5,'h12,0,0,0,'h14,0,0,0};
    vecs[4]  = '{1,0,'h18,9,1,'h99,0,0,0,0,0,0,0,0, 0,1,5,'h12,0,0,0,'h14,0,0,0};
    vecs[5]  = '{0,0,'h18,9,1,'h99,0,0,0,0,0,0,0,0, 0,1,9,'h99,0,0,0,'h18,0,0,0};
    vecs[6]  = '{1,1,'h1c,3,1,'h33,0,'h200,0,5,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1};
    vecs[7]  = '{0,0,'h40,4,1,'h44,0,'h102,0,5,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,2};
    vecs[8]  = '{0,0,'h44,6,1,'h66,0,'h102,0,3,0,0,0,0, 3,1,6,'h66,0,'h102,0,'h44,0,0,2};
    vecs[9]  = '{0,0,'h48,0,0,0,1,'h103,'hAB,6,0,0,0,0, 6,0,0,0,1,'h103,'hAB,'h48,0,0,2};
    vecs[10] = '{0,0,'h4c,7,1,0,0,'h300,0,5,0,0,7,1, 5,1,7,0,0,'h300,0,'h4c,0,1,2};
    vecs[11] = '{0,0,'h50,0,1,0,0,'h300,0,5,0,0,0,1, 5,1,0,0,0,'h300,0,'h50,0,0,2};
    vecs[12] = '{0,0,'h54,7,1,0,0,'h300,0,5,7,0,7,0, 5,1,7,0,0,'h300,0,'h54,0,0,2};
    vecs[13] = '{0,0,'h58,7,1,0,0,'h301,0,2,7,1,0,0, 2,1,7,0,0,'h301,0,'h58,0,1,2};
    vecs[14] = '{0,0,'h60,0,0,0,1,'h302,'h55,8,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,3};
    vecs[15] = '{1,0,'h64,1,1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,3};
    vecs[16] = '{0,0,'h64,8,1,0,0,'h105,0,4,0,0,0,0, 0,0,0,0,0,0,0,0,1,0,4};
    vecs[17] = '{0,0,'h68,2,1,'h22,0,'h107,0,'hF,0,0,2,1, 'hF,1,2,'h22,0,'h107,0,'h68,0,0,4};

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check_bubble("reset");
    check("reset_mis", -1, {31'd0, mis_o}, 32'd0);
    check("reset_cnt", -1, {16'd0, cnt_o}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      stall = vecs[i].stall; flush = vecs[i].flush; pc = vecs[i].pc;
      waddr = vecs[i].waddr; we = vecs[i].we; wdata = vecs[i].wdata;
      mem_we = vecs[i].mem_we; addr = vecs[i].addr; mdata = vecs[i].mdata;
      op = vecs[i].op; rs1 = vecs[i].rs1; rs1re = vecs[i].rs1re;
      rs2 = vecs[i].rs2; rs2re = vecs[i].rs2re;
      #1;
      check("load_use", i, {31'd0, lu_o}, {31'd0, vecs[i].e_lu});
      @(posedge clk);
      #1;
      check("mem_op", i, {28'd0, op_o}, {28'd0, vecs[i].e_op});
      check("reg_we", i, {31'd0, we_o}, {31'd0, vecs[i].e_we});
      check("reg_waddr", i, {27'd0, waddr_o}, {27'd0, vecs[i].e_waddr});
      check("reg_wdata", i, wdata_o, vecs[i].e_wdata);
      check("mem_we", i, {31'd0, mem_we_o}, {31'd0, vecs[i].e_mem_we});
      check("mem_addr", i, addr_o, vecs[i].e_addr);
      check("mem_data", i, mdata_o, vecs[i].e_mdata);
      check("pc", i, pc_o, vecs[i].e_pc);
      check("misalign", i, {31'd0, mis_o}, {31'd0, vecs[i].e_mis});
      check("bubble_cnt", i, {16'd0, cnt_o}, {16'd0, vecs[i].e_cnt});
      if (i == 8) begin
        check("mis_addr_held", i, mis_addr_o, 32'h102);
        check("mis_pc_held", i, mis_pc_o, 32'h40);
      end
    end
    check("mis_addr_last", -1, mis_addr_o, 32'h105);
    check("mis_pc_last", -1, mis_pc_o, 32'h64);

    // 20 back-to-back flushes: 4-bit counter starts at 4 and must pin at 15.
    @(negedge clk);
    drive_idle();
    flush = 1;
    op = 4'd5; we = 1; waddr = 5'd3; addr = 32'h200; pc = 32'h70;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) check("cnt4_reach15", k, {28'd0, cnt4_o}, 32'd15);
    end
    check("cnt4_saturated", -1, {28'd0, cnt4_o}, 32'd15);
    check("cnt16_after_flushes", -1, {16'd0, cnt_o}, 32'd24);
    check_bubble("flush_run");

    // Reset while a load-use pattern is on the inputs.
    @(negedge clk);
    drive_idle();
    op = 4'd5; we = 1; waddr = 5'd7; rs2 = 5'd7; rs2re = 1; stall = 1;
    rst = 1;
    #1;
    check("load_use_in_reset", -1, {31'd0, lu_o}, 32'd0);
    @(posedge clk);
    #1;
    check("cnt4_after_reset", -1, {28'd0, cnt4_o}, 32'd0);
    check("cnt16_after_reset", -1, {16'd0, cnt_o}, 32'd0);
    check("mis_addr_after_reset", -1, mis_addr_o, 32'd0);
    check("mis_pc_after_reset", -1, mis_pc_o, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    check("load_use_after_reset", -1, {31'd0, lu_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
